// File: rtl/operand_sequencer_pkg.sv
// Shared matrix-accelerator definitions: operand geometry and sequencer state encoding.
package operand_sequencer_pkg;

  localparam int N_DIM = 4;
  localparam int OP_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLR  = 2'd1,
    ST_MAC  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/operand_sequencer_store.sv
// 16-entry operand register array: one synchronous write port, one combinational read port.
module operand_store #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < DEPTH; n++) mem[n] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/operand_sequencer.sv
// Streams A[i][k] / B[k][j] operand pairs to a downstream MAC for a full 4x4 matrix product,
// tagging each completed dot product with its (i,j) position.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | stores writable, waiting for start
//   CLR     | one-cycle accumulator clear before each dot product
//   MAC     | four accumulate cycles, k = 0..3
//   DONE    | one-cycle completion pulse alongside the final res_valid
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int N  = N_DIM,
  parameter int DW = OP_DW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic                    wr_sel,
  input  logic [2*$clog2(N)-1:0]  wr_addr,
  input  logic [DW-1:0]           wr_data,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    mac_clr,
  output logic                    mac_en,
  output logic [DW-1:0]           a_out,
  output logic [DW-1:0]           b_out,
  output logic                    res_valid,
  output logic [$clog2(N)-1:0]    res_row,
  output logic [$clog2(N)-1:0]    res_col
);

  localparam int IW = $clog2(N);
  localparam int AW = 2 * IW;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  seq_state_e    state;
  logic [IW-1:0] i, j, k, k_nxt;
  logic [AW-1:0] a_raddr, b_raddr;
  logic [DW-1:0] a_rd, b_rd;
  logic          a_we, b_we;

  // Writes only land while idle so a running product never sees its operands change.
  assign a_we = wr_en && !wr_sel && (state == ST_IDLE);
  assign b_we = wr_en &&  wr_sel && (state == ST_IDLE);

  // Operands are registered, so the stores are read at the index of the coming MAC cycle.
  always_comb begin
    k_nxt   = '0;
    if (state == ST_MAC) k_nxt = k + 1'b1;
    a_raddr = {i, k_nxt};
    b_raddr = {k_nxt, j};
  end

  operand_store #(.DW(DW), .DEPTH(N * N), .AW(AW)) u_store_a (
    .clk   (clk),
    .reset (reset),
    .we    (a_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (a_raddr),
    .rdata (a_rd)
  );

  operand_store #(.DW(DW), .DEPTH(N * N), .AW(AW)) u_store_b (
    .clk   (clk),
    .reset (reset),
    .we    (b_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (b_raddr),
    .rdata (b_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mac_clr   <= 1'b0;
      mac_en    <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
      res_valid <= 1'b0;
      res_row   <= '0;
      res_col   <= '0;
    end else begin
      done      <= 1'b0;
      mac_clr   <= 1'b0;
      mac_en    <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
      res_valid <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_CLR;
            busy    <= 1'b1;
            mac_clr <= 1'b1;
            i       <= '0;
            j       <= '0;
            k       <= '0;
          end
        end

        ST_CLR: begin
          state  <= ST_MAC;
          k      <= '0;
          mac_en <= 1'b1;
          a_out  <= a_rd;
          b_out  <= b_rd;
        end

        ST_MAC: begin
          if (k != LAST) begin
            k      <= k_nxt;
            mac_en <= 1'b1;
            a_out  <= a_rd;
            b_out  <= b_rd;
          end else begin
            // The MAC result appears one cycle later, so the tag is launched alongside it.
            res_valid <= 1'b1;
            res_row   <= i;
            res_col   <= j;
            k         <= '0;
            if (i == LAST && j == LAST) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state   <= ST_CLR;
              mac_clr <= 1'b1;
              if (j == LAST) begin
                j <= '0;
                i <= i + 1'b1;
              end else begin
                j <= j + 1'b1;
              end
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          i     <= '0;
          j     <= '0;
          k     <= '0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_sequencer.sv
// Randomized bench: drives the sequencer into a modelled downstream MAC and compares every
// tagged result against C = A x B computed directly from a shadow copy of the operand stores.
module tb_operand_sequencer;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en, wr_sel, start;
  logic [3:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy, done, mac_clr, mac_en, res_valid;
  logic [DW-1:0] a_out, b_out;
  logic [1:0]    res_row, res_col;

  int n_chk = 0;
  int n_err = 0;
  int acc;
  int a_m[16];
  int b_m[16];
  int c00;
  int n_ovf;

  operand_sequencer #(.N(4), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mac_clr   (mac_clr),
    .mac_en    (mac_en),
    .a_out     (a_out),
    .b_out     (b_out),
    .res_valid (res_valid),
    .res_row   (res_row),
    .res_col   (res_col)
  );

  always #5 clk = ~clk;

  // Downstream MAC: registered accumulator, wide enough to expose 16-bit overflow.
  always @(posedge clk) begin
    if (reset || mac_clr) acc <= 0;
    else if (mac_en) acc <= acc + int'(a_out) * int'(b_out);
  end

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int c_ref(input int r, input int c);
    int s = 0;
    for (int q = 0; q < 4; q++) s += a_m[r*4+q] * b_m[q*4+c];
    return s;
  endfunction

  task automatic load(input bit sel, input int addr, input int data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = addr[3:0];
    wr_data = data[7:0];
    tick;
    wr_en = 1'b0;
    if (sel) b_m[addr] = data & 255;
    else     a_m[addr] = data & 255;
  endtask

  task automatic go;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Entered in the CLR cycle right after start; returns in the DONE cycle.
  // Latency counts the start cycle as 1 and the done cycle inclusively.
  task automatic run_body(input bit noisy);
    int p = 0;
    int cyc = 1;
    int clr_n = 0;
    int en_n = 0;
    int stray = 0;
    int idle_n = 0;
    bit fin = 0;
    n_ovf = 0;
    while (!fin && cyc < 200) begin
      if (mac_clr) clr_n++;
      if (mac_en) en_n++;
      if (!mac_en && (a_out != 0 || b_out != 0)) stray++;
      if (!busy) idle_n++;
      if (res_valid) begin
        chk("res_row", res_row, p / 4);
        chk("res_col", res_col, p % 4);
        chk("c_value", acc, c_ref(p / 4, p % 4));
        if (p == 0) c00 = acc;
        if (acc > 65535) n_ovf++;
        p++;
      end
      if (done) begin
        fin = 1;
        chk("latency", cyc + 1, 82);
        chk("pulses", p, 16);
      end else begin
        if (noisy) begin
          wr_en   = 1'($urandom_range(0, 1));
          wr_sel  = 1'($urandom_range(0, 1));
          wr_addr = 4'($urandom_range(0, 15));
          wr_data = 8'hFF;
        end
        tick;
        cyc++;
      end
    end
    wr_en = 1'b0;
    if (!fin) chk("run_timeout", 0, 1);
    chk("mac_clr_count", clr_n, 16);
    chk("mac_en_count", en_n, 64);
    chk("stray_operands", stray, 0);
    chk("busy_low_in_run", idle_n, 0);
  endtask

  task automatic idle_after;
    tick;
    chk("busy_after_done", busy, 0);
    chk("done_width", done, 0);
  endtask

  task automatic load_random;
    for (int e = 0; e < 16; e++) begin
      load(0, e, int'($urandom_range(0, 255)));
      load(1, e, int'($urandom_range(0, 255)));
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    for (int e = 0; e < 16; e++) begin a_m[e] = 0; b_m[e] = 0; end
    repeat (3) tick;
    reset = 1'b0;
    chk("reset_outputs", {busy, done, mac_clr, mac_en, res_valid, a_out, b_out, res_row, res_col}, 0);

    // A row0 = 1..4, B col0 = 4..7
    for (int e = 0; e < 4; e++) begin
      load(0, e, e + 1);
      load(1, e * 4, e + 4);
    end
    go;
    run_body(0);
    chk("c00_basic", c00, 60);
    idle_after;

    // Identity A, B[r][c] = r*4+c, with dropped writes during the run
    for (int e = 0; e < 16; e++) begin
      load(0, e, (e / 4 == e % 4) ? 1 : 0);
      load(1, e, e);
    end
    go;
    run_body(1);
    idle_after;
    go;
    run_body(0);
    // start in DONE is ignored, start on the next cycle is accepted
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("start_in_done_ignored", busy, 0);
    go;
    chk("busy_after_restart", busy, 1);
    run_body(1);
    idle_after;

    // Random operands; final write shares its cycle with start
    load_random;
    wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 4'd15; wr_data = 8'd200;
    b_m[15] = 200;
    go;
    wr_en = 1'b0;
    run_body(1);
    idle_after;

    // Reset at cycle 30 of a run
    go;
    repeat (29) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("midrun_reset_outputs", {busy, done, mac_clr, mac_en, res_valid, a_out, b_out, res_row, res_col}, 0);
    for (int e = 0; e < 16; e++) begin a_m[e] = 0; b_m[e] = 0; end
    go;
    run_body(0);
    idle_after;
    load_random;
    go;
    run_body(0);
    idle_after;

    // Saturated operands overflow a 16-bit MAC on every product
    for (int e = 0; e < 16; e++) begin
      load(0, e, 255);
      load(1, e, 255);
    end
    go;
    run_body(0);
    chk("c00_sat", c00, 260100);
    chk("overflow_count", n_ovf, 16);
    idle_after;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
